// File: rtl/prog_loop_divider.sv
// prog_loop_divider: programmable integer loop divider for the PLL feedback path.
// Optional first-order fractional division is enabled by defining LOOP_DIV_FRAC_EN.
// Ratio updates go through a shadow register and commit only at a period boundary,
// so the divided clock never sees a shortened or stretched period.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | stopped, counter parked at 0, clko low
// S_RUN   | dividing, counter wraps 0..P-1 continuously
// S_DRAIN | run request dropped, finishing current period then stopping
module prog_loop_divider #(
    parameter int DIV_W   = 8,
    parameter int FRAC_W  = 8,
    parameter int DIV_DEF = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_n,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_busy,
    output logic              div_ack,
    output logic              div_err,
    output logic              clko,
    output logic              clkob,
    output logic              sync_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [DIV_W-1:0] N_DEF = DIV_W'(DIV_DEF);
    localparam logic [DIV_W-1:0] N_MAX = {DIV_W{1'b1}};

    state_t             r_state;
    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_p;
    logic [DIV_W-1:0]   r_n_act;
    logic [DIV_W-1:0]   r_n_sh;
    logic               r_busy;
    logic               r_ack;
    logic               r_err;
    logic               r_clko;
    logic               r_sync;

    state_t             w_state_next;
    logic [DIV_W-1:0]   w_cnt_next;
    logic [DIV_W-1:0]   w_p_next;
    logic [DIV_W-1:0]   w_n_next;
    logic [DIV_W-1:0]   w_p_start;
    logic [DIV_W:0]     w_h;
    logic               w_term;
    logic               w_start;
    logic               w_commit;
    logic               w_accept;
    logic               w_reject;
    logic               w_carry;
    logic               w_clko_next;

    assign w_term   = (r_state != S_IDLE) && (r_cnt == r_p - 1'b1);
    // A new period begins either leaving IDLE or wrapping at the terminal count.
    assign w_start  = en && ((r_state == S_IDLE) || w_term);
    // Shadow commits only at a period boundary, or immediately while stopped.
    assign w_commit = r_busy && ((r_state == S_IDLE) || w_start);
    assign w_accept = div_load && !r_busy && (div_n >= DIV_W'(2));
    assign w_reject = div_load && (r_busy || (div_n < DIV_W'(2)));
    assign w_n_next = w_commit ? r_n_sh : r_n_act;

`ifdef LOOP_DIV_FRAC_EN
    logic [FRAC_W-1:0]  r_frac_sh;
    logic [FRAC_W-1:0]  r_frac_act;
    logic [FRAC_W-1:0]  r_acc;
    logic [FRAC_W:0]    w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_frac_act};
    // A committing period starts from a cleared accumulator, so it never carries.
    assign w_carry = w_sum[FRAC_W] && !w_commit && (r_n_act != N_MAX);

    // Fractional shadow/active ratio and phase accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frac_sh  <= '0;
            r_frac_act <= '0;
            r_acc      <= '0;
        end else begin
            if (w_accept)
                r_frac_sh <= div_frac;
            if (w_commit) begin
                r_frac_act <= r_frac_sh;
                r_acc      <= '0;
            end else if (w_start) begin
                r_acc <= w_sum[FRAC_W-1:0];
            end
        end
    end
`else
    logic w_unused_frac;

    assign w_carry       = 1'b0;
    assign w_unused_frac = ^div_frac;
`endif

    assign w_p_start = w_n_next + {{(DIV_W-1){1'b0}}, w_carry};

    // Next counter, period length, state and divided-clock level.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_p_next     = r_p;
        if (w_start) begin
            w_state_next = S_RUN;
            w_cnt_next   = '0;
            w_p_next     = w_p_start;
        end else if (r_state == S_IDLE) begin
            w_state_next = S_IDLE;
        end else if (w_term) begin
            w_state_next = S_IDLE;
        end else begin
            w_state_next = en ? S_RUN : S_DRAIN;
            w_cnt_next   = r_cnt + 1'b1;
        end
        w_h         = ({1'b0, w_p_next} + (DIV_W+1)'(1)) >> 1;
        w_clko_next = (w_state_next != S_IDLE) && ({1'b0, w_cnt_next} < w_h);
    end

    // Main sequencer: counter, state and registered clock/sync outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_p     <= N_DEF;
            r_clko  <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_p     <= w_p_next;
            r_clko  <= w_clko_next;
            r_sync  <= w_start;
        end
    end

    // Ratio load handshake: shadow capture, commit, ack/err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n_act <= N_DEF;
            r_n_sh  <= N_DEF;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= w_commit;
            r_err <= w_reject;
            if (w_commit) begin
                r_n_act <= r_n_sh;
                r_busy  <= 1'b0;
            end else if (w_accept) begin
                r_n_sh <= div_n;
                r_busy <= 1'b1;
            end
        end
    end

    assign clko       = r_clko;
    assign clkob      = ~r_clko;
    assign sync_pulse = r_sync;
    assign div_busy   = r_busy;
    assign div_ack    = r_ack;
    assign div_err    = r_err;

endmodule

// File: tb/tb_prog_loop_divider.sv
// tb_prog_loop_divider: random stimulus against a period-queue reference model.
module tb_prog_loop_divider;

    localparam int DIV_W  = 8;
    localparam int FRAC_W = 8;
`ifdef LOOP_DIV_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [DIV_W-1:0]  div_n = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              div_load = 1'b0;
    logic              div_busy, div_ack, div_err, clko, clkob, sync_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit   m_active;
    bit   m_rem[$];
    int   m_n_act, m_n_sh, m_f_act, m_f_sh, m_acc;
    bit   m_busy;
    bit   e_clko, e_sync, e_ack, e_err;
    int   period_log[$];

    prog_loop_divider #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .DIV_DEF(4)) dut (
        .clk(clk), .rst(rst), .en(en), .div_n(div_n), .div_frac(div_frac),
        .div_load(div_load), .div_busy(div_busy), .div_ack(div_ack),
        .div_err(div_err), .clko(clko), .clkob(clkob), .sync_pulse(sync_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_rem.delete();
        m_n_act = 4; m_n_sh = 4; m_f_act = 0; m_f_sh = 0; m_acc = 0;
        m_busy = 0;
        e_clko = 0; e_sync = 0; e_ack = 0; e_err = 0;
    endtask

    // Predict what the next clock edge produces for the given inputs.
    task automatic model_step(input bit i_en, input bit i_load, input int i_n, input int i_f);
        bit accept, period_end, start, commit, carry;
        int p, h;
        e_err      = i_load && (m_busy || i_n < 2);
        accept     = i_load && !m_busy && i_n >= 2;
        period_end = !m_active || (m_rem.size() == 0);
        start      = period_end && i_en;
        commit     = m_busy && (!m_active || start);
        e_ack      = commit;
        e_sync     = start;
        if (commit) begin
            m_n_act = m_n_sh;
            m_f_act = m_f_sh;
            m_acc   = 0;
        end
        if (start) begin
            carry = 0;
            if (!commit) begin
                m_acc = m_acc + m_f_act;
                if (m_acc >= (1 << FRAC_W)) begin
                    carry = 1;
                    m_acc = m_acc - (1 << FRAC_W);
                end
            end
            p = m_n_act + ((carry && m_n_act != (1 << DIV_W) - 1) ? 1 : 0);
            period_log.push_back(p);
            h = (p + 1) / 2;
            m_rem.delete();
            for (int i = 1; i < p; i++) m_rem.push_back(i < h);
            e_clko   = 1;
            m_active = 1;
        end else if (m_active && m_rem.size() != 0) begin
            e_clko = m_rem.pop_front();
        end else begin
            m_active = 0;
            e_clko   = 0;
        end
        if (commit) m_busy = 0;
        else if (accept) begin
            m_busy = 1;
            m_n_sh = i_n;
            m_f_sh = FRAC_ON ? i_f : 0;
        end
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, ".clko"},  {31'd0, clko},       {31'd0, e_clko});
        check({pfx, ".clkob"}, {31'd0, clkob},      {31'd0, ~e_clko});
        check({pfx, ".sync"},  {31'd0, sync_pulse}, {31'd0, e_sync});
        check({pfx, ".ack"},   {31'd0, div_ack},    {31'd0, e_ack});
        check({pfx, ".err"},   {31'd0, div_err},    {31'd0, e_err});
        check({pfx, ".busy"},  {31'd0, div_busy},   {31'd0, m_busy});
    endtask

    task automatic cycle(input bit i_en, input bit i_load, input int i_n, input int i_f, input string pfx);
        en       = i_en;
        div_load = i_load;
        div_n    = DIV_W'(i_n);
        div_frac = FRAC_W'(i_f);
        model_step(i_en, i_load, i_n, i_f);
        @(posedge clk);
        #1;
        compare_all(pfx);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, ".clko"},  {31'd0, clko},       32'd0);
        check({pfx, ".clkob"}, {31'd0, clkob},      32'd1);
        check({pfx, ".sync"},  {31'd0, sync_pulse}, 32'd0);
        check({pfx, ".busy"},  {31'd0, div_busy},   32'd0);
        check({pfx, ".ack"},   {31'd0, div_ack},    32'd0);
        check({pfx, ".err"},   {31'd0, div_err},    32'd0);
    endtask

    initial begin
        int en_run, n, f, sum;
        bit ld;
        model_reset();
        #23;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // default N=4 free-running: 1,1,0,0
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, "dflt");
        // N=5 load, then odd duty
        cycle(1, 1, 5, 0, "ld5");
        for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0, "n5");
        // bad ratio and load while busy
        cycle(1, 1, 1, 0, "ld1");
        cycle(1, 1, 6, 0, "ld6");
        cycle(1, 1, 9, 0, "ldbusy");
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, "n6");
        // N=8, stop mid-period, then restart during drain
        cycle(1, 1, 8, 0, "ld8");
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, "n8");
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, "drain");
        for (int i = 0; i < 3; i++)  cycle(1, 0, 0, 0, "rerun");
        for (int i = 0; i < 2; i++)  cycle(0, 0, 0, 0, "drain2");
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, "resume");

        // fractional N=4 F=0x80 (integer-only build sees N=4 throughout)
        cycle(1, 1, 4, 128, "ldfrac");
        while (!e_sync) cycle(1, 0, 0, 0, "wsync");
        period_log.delete();
        for (int i = 0; i < 200 && period_log.size() < 17; i++) cycle(1, 0, 0, 0, "frac");
        sum = 0;
        for (int i = 0; i < 16 && i < period_log.size(); i++) sum += period_log[i];
        check("frac16", sum, FRAC_ON ? 72 : 64);

        // randomized phase
        en_run = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en_run = !en_run;
            ld = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 9))
                0:       n = $urandom_range(0, 1);
                1:       n = 255;
                default: n = $urandom_range(2, 12);
            endcase
            f = $urandom_range(0, 255);
            cycle(en_run[0], ld, n, f, "rand");
        end

        // asynchronous reset mid-run
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, "prerst");
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("asyncrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, "postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
